// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM state encoding and
// instruction-field helpers that work for any DATA_W/ADDR_W up to WORD_MAX bits.
package acc_cpu_pkg;

    localparam int WORD_MAX = 64;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;
    localparam logic [3:0] OP_JN  = 4'd10;
    localparam logic [3:0] OP_HLT = 4'd11;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_IND,
        ST_OPER,
        ST_STORE,
        ST_HALT
    } state_e;

    // Fields are extracted by shifting a zero-extended word, so one function
    // serves every instance width.
    function automatic logic [3:0] instr_opcode(input logic [WORD_MAX-1:0] ir, input int data_w);
        return 4'((ir >> (data_w - 5)) & WORD_MAX'(15));
    endfunction

    function automatic logic instr_indirect(input logic [WORD_MAX-1:0] ir, input int data_w);
        return 1'((ir >> (data_w - 1)) & WORD_MAX'(1));
    endfunction

    function automatic logic [WORD_MAX-1:0] instr_addr(input logic [WORD_MAX-1:0] ir, input int addr_w);
        return ir & ((WORD_MAX'(1) << addr_w) - WORD_MAX'(1));
    endfunction

    function automatic logic has_mem_operand(input logic [3:0] op);
        return (op >= OP_LDA) && (op <= OP_OR);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: produces the new accumulator value for
// LDA/ADD/SUB/AND/OR/NOT; other opcodes pass the accumulator through.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] operand,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = acc_in;
        case (opcode)
            OP_LDA:  result = operand;
            OP_ADD:  result = acc_in + operand;
            OP_SUB:  result = acc_in - operand;
            OP_AND:  result = acc_in & operand;
            OP_OR:   result = acc_in | operand;
            OP_NOT:  result = ~acc_in;
            default: result = acc_in;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator processor: fetch/decode/indirect/operand/store FSM
// driving one shared req/ready memory port.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        op;
    logic              ind;
    logic [ADDR_W-1:0] addr_f;
    logic [DATA_W-1:0] alu_res;
    logic              req_c;
    logic              retire_c;

    assign op     = instr_opcode(WORD_MAX'(ir_q), DATA_W);
    assign ind    = instr_indirect(WORD_MAX'(ir_q), DATA_W);
    assign addr_f = ADDR_W'(instr_addr(WORD_MAX'(ir_q), ADDR_W));

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .acc_in  (acc_q),
        .operand (mem_rdata),
        .opcode  (op),
        .result  (alu_res)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ea_d      = ea_q;
        acc_d     = acc_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        req_c     = 1'b0;
        retire_c  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;

        case (state_q)
            ST_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (has_mem_operand(op)) begin
                    ea_d = addr_f;
                    if (ind)
                        state_d = ST_IND;
                    else
                        state_d = (op == OP_STA) ? ST_STORE : ST_OPER;
                end else begin
                    // Jump conditions look at the accumulator as it stands now.
                    case (op)
                        OP_NOP: retire_c = 1'b1;
                        OP_NOT: begin
                            acc_d    = alu_res;
                            retire_c = 1'b1;
                        end
                        OP_JMP: begin
                            pc_d     = addr_f;
                            retire_c = 1'b1;
                        end
                        OP_JZ: begin
                            if (acc_q == '0)
                                pc_d = addr_f;
                            retire_c = 1'b1;
                        end
                        OP_JN: begin
                            if (acc_q[DATA_W-1])
                                pc_d = addr_f;
                            retire_c = 1'b1;
                        end
                        OP_HLT: begin
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end
                        default: begin
                            halted_d  = 1'b1;
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
                        end
                    endcase
                end
            end
            ST_IND: begin
                req_c    = 1'b1;
                mem_addr = addr_f;
                if (mem_ready) begin
                    ea_d    = ADDR_W'(mem_rdata);
                    state_d = (op == OP_STA) ? ST_STORE : ST_OPER;
                end
            end
            ST_OPER: begin
                req_c    = 1'b1;
                mem_addr = ea_q;
                if (mem_ready) begin
                    acc_d    = alu_res;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_STORE: begin
                req_c    = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ea_q;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            ea_q      <= '0;
            acc_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ea_q      <= ea_d;
            acc_q     <= acc_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset kills any in-flight transaction in the same cycle it is raised.
    assign mem_req   = req_c & ~rst;
    assign retire    = retire_c & ~rst;
    assign mem_wdata = acc_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: a behavioural memory with optional wait
// states and a scoreboard of expected bus transactions in program order.
module tb_acc_cpu_core;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          retire;
    logic          halted;
    logic          illegal;

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(10'h000)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .acc       (acc),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t        sb[$];
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          n_retire = 0;
    int          ws_cfg   = 0;
    int          ws_cnt   = 0;
    logic [52:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input logic [AW-1:0] a);
        sb.push_back({1'b0, a, 16'h0000});
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back({1'b1, a, d});
    endtask

    // One clock cycle: sample mid-cycle, score any handshake, then step past
    // the rising edge and present the memory's ready for the next cycle.
    task automatic tick();
        logic nr;
        txn_t got;
        txn_t e;
        @(negedge clk);
        cyc++;
        nr = mem_ready;
        if (retire) n_retire++;
        if (mem_req && !mem_ready) begin
            if (ws_cnt == 0) begin
                held = {mem_addr, mem_we, mem_wdata, pc, acc};
            end else begin
                checks++;
                assert ({mem_addr, mem_we, mem_wdata, pc, acc} === held)
                else begin
                    errors++;
                    $error("FAIL wait_stable: observed %h expected %h",
                           {mem_addr, mem_we, mem_wdata, pc, acc}, held);
                end
            end
            ws_cnt++;
            nr = (ws_cnt >= ws_cfg);
        end else if (mem_req) begin
            got = {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0000};
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL bus_extra: observed %h expected no transaction", got);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (got === e)
                else begin
                    errors++;
                    $error("FAIL bus_txn: observed %h expected %h", got, e);
                end
            end
            if (mem_we) mem[mem_addr] = mem_wdata;
            ws_cnt = 0;
            nr = (ws_cfg == 0);
        end
        @(posedge clk);
        #1;
        mem_ready = nr;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ws_cnt    = 0;
        mem_ready = (ws_cfg == 0);
        sb.delete();
        tick();
        tick();
        chk("reset_pc", 32'(pc), 32'h000);
        chk("reset_acc", 32'(acc), 32'h0000);
        chk("reset_flags", {28'h0, halted, illegal, retire, mem_req}, 32'h0);
        rst      = 1'b0;
        cyc      = 0;
        n_retire = 0;
    endtask

    task automatic run_to_halt(input int max_cyc);
        while (!halted && cyc < max_cyc) tick();
        chk("halt_reached", 32'(halted), 32'h1);
    endtask

    task automatic load_sum_prog();
        clear_mem();
        mem[0] = 16'h0900; mem[1] = 16'h1901; mem[2] = 16'h1102; mem[3] = 16'h5800;
        mem[10'h100] = 16'h0005; mem[10'h101] = 16'h0007;
    endtask

    task automatic push_sum_prog();
        exp_rd(10'h000); exp_rd(10'h100);
        exp_rd(10'h001); exp_rd(10'h101);
        exp_rd(10'h002); exp_wr(10'h102, 16'h000C);
        exp_rd(10'h003);
    endtask

    initial begin
        logic found;

        // Program run, zero wait states
        ws_cfg = 0;
        load_sum_prog();
        do_reset();
        push_sum_prog();
        run_to_halt(100);
        chk("sum_cycles", 32'(cyc), 32'd11);
        chk("sum_pc", 32'(pc), 32'h004);
        chk("sum_retires", 32'(n_retire), 32'd3);
        chk("sum_acc", 32'(acc), 32'h000C);
        chk("sum_mem", 32'(mem[10'h102]), 32'h000C);
        chk("sum_illegal", 32'(illegal), 32'h0);
        chk("sum_sb_empty", 32'(sb.size()), 32'd0);

        // Indirect load followed by a taken JN
        clear_mem();
        mem[0] = 16'h8900; mem[1] = 16'h5050; mem[10'h050] = 16'h5800;
        mem[10'h100] = 16'h0200; mem[10'h200] = 16'hBEEF;
        do_reset();
        exp_rd(10'h000); exp_rd(10'h100); exp_rd(10'h200);
        exp_rd(10'h001); exp_rd(10'h050);
        repeat (4) tick();
        chk("ind_acc", 32'(acc), 32'hBEEF);
        run_to_halt(100);
        chk("ind_pc", 32'(pc), 32'h051);
        chk("ind_sb_empty", 32'(sb.size()), 32'd0);

        // Same program as the first run with three wait cycles per access
        ws_cfg = 3;
        load_sum_prog();
        do_reset();
        push_sum_prog();
        run_to_halt(200);
        chk("ws_cycles", 32'(cyc), 32'd32);
        chk("ws_retires", 32'(n_retire), 32'd3);
        chk("ws_mem", 32'(mem[10'h102]), 32'h000C);
        chk("ws_sb_empty", 32'(sb.size()), 32'd0);
        ws_cfg = 0;

        // JZ taken with acc == 0, not taken with acc == 1
        clear_mem();
        mem[0] = 16'h0900; mem[1] = 16'h4850;
        mem[10'h050] = 16'h0901; mem[10'h051] = 16'h4850; mem[10'h052] = 16'h5800;
        mem[10'h100] = 16'h0000; mem[10'h101] = 16'h0001;
        do_reset();
        exp_rd(10'h000); exp_rd(10'h100); exp_rd(10'h001);
        exp_rd(10'h050); exp_rd(10'h101); exp_rd(10'h051); exp_rd(10'h052);
        run_to_halt(100);
        chk("jz_pc", 32'(pc), 32'h053);
        chk("jz_retires", 32'(n_retire), 32'd4);
        chk("jz_sb_empty", 32'(sb.size()), 32'd0);

        // PC wrap at 0x3FF, acc wrap 0xFFFF + 2, then NOT and store
        clear_mem();
        mem[0] = 16'h4BFF; mem[10'h3FF] = 16'h0900; mem[1] = 16'h1901;
        mem[2] = 16'h3800; mem[3] = 16'h1102; mem[4] = 16'h5800;
        mem[10'h100] = 16'hFFFF; mem[10'h101] = 16'h0002;
        do_reset();
        exp_rd(10'h000); exp_rd(10'h3FF); exp_rd(10'h100); exp_rd(10'h000);
        exp_rd(10'h001); exp_rd(10'h101); exp_rd(10'h002); exp_rd(10'h003);
        exp_wr(10'h102, 16'hFFFE); exp_rd(10'h004);
        run_to_halt(100);
        chk("wrap_acc", 32'(acc), 32'hFFFE);
        chk("wrap_pc", 32'(pc), 32'h005);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // AND / OR / SUB chain
        clear_mem();
        mem[0] = 16'h0900; mem[1] = 16'h2901; mem[2] = 16'h3102;
        mem[3] = 16'h2103; mem[4] = 16'h1104; mem[5] = 16'h5800;
        mem[10'h100] = 16'h0F0F; mem[10'h101] = 16'h00FF;
        mem[10'h102] = 16'h1200; mem[10'h103] = 16'h0010;
        do_reset();
        exp_rd(10'h000); exp_rd(10'h100); exp_rd(10'h001); exp_rd(10'h101);
        exp_rd(10'h002); exp_rd(10'h102); exp_rd(10'h003); exp_rd(10'h103);
        exp_rd(10'h004); exp_wr(10'h104, 16'h11FF); exp_rd(10'h005);
        run_to_halt(100);
        chk("alu_acc", 32'(acc), 32'h11FF);
        chk("alu_pc", 32'(pc), 32'h006);
        chk("alu_sb_empty", 32'(sb.size()), 32'd0);

        // Illegal opcode 15
        clear_mem();
        mem[0] = 16'h7800;
        do_reset();
        exp_rd(10'h000);
        run_to_halt(50);
        chk("ill_cycles", 32'(cyc), 32'd2);
        chk("ill_flags", {30'h0, halted, illegal}, 32'h3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ill_req_low", 32'(mem_req), 32'h0);
        end
        chk("ill_retires", 32'(n_retire), 32'd0);
        chk("ill_pc", 32'(pc), 32'h001);

        // Reset raised while ADD waits for its operand
        ws_cfg = 3;
        clear_mem();
        mem[0] = 16'h0900; mem[1] = 16'h1900; mem[10'h100] = 16'h0005;
        do_reset();
        exp_rd(10'h000); exp_rd(10'h100); exp_rd(10'h001);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mem_req && !mem_ready && mem_addr == 10'h100 && acc == 16'h0005) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_wait_found", 32'(found), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'h0);
        tick();
        chk("rst_pc", 32'(pc), 32'h000);
        chk("rst_acc", 32'(acc), 32'h0000);
        chk("rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
